// File: rtl/uart_sram_tx_interface_pkg.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface_pkg
// Shared types for the SRAM-to-UART dump path.
//   - top_state_type : top-level SRAM owner selection. S_UART_TX_TOP_STATE
//                      hands SRAM_address / SRAM_we_n to the transmit block.
//   - tx_state_type  : word sequencer states of uart_sram_tx_interface.
//   - ser_state_type : byte serialiser states of uart_tx_byte.
//   - next_sram_address : word address increment with 18-bit wrap.
// -----------------------------------------------------------------------------
package uart_sram_tx_interface_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    // Which interface currently drives the SRAM controller at the top level.
    typedef enum logic [2:0] {
        S_IDLE_TOP_STATE    = 3'd0,
        S_UART_RX_TOP_STATE = 3'd1,
        S_M1_TOP_STATE      = 3'd2,
        S_M2_TOP_STATE      = 3'd3,
        S_UART_TX_TOP_STATE = 3'd4
    } top_state_type;

    typedef enum logic [2:0] {
        S_TX_IDLE    = 3'd0,
        S_TX_WAIT    = 3'd1,
        S_TX_LATCH   = 3'd2,
        S_TX_SEND_HI = 3'd3,
        S_TX_SEND_LO = 3'd4,
        S_TX_DONE    = 3'd5
    } tx_state_type;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_type;

    // The address space is a full 18-bit range, so the natural carry-out
    // discard gives the 3FFFF -> 00000 wrap.
    function automatic logic [SRAM_ADDR_W-1:0] next_sram_address(
        input logic [SRAM_ADDR_W-1:0] addr
    );
        return addr + 18'd1;
    endfunction

endpackage

// File: rtl/uart_sram_tx_interface_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 byte serialiser: start bit 0, d0..d7, stop bit 1, each bit held for
// CLKS_PER_BIT clocks.
//   clk, rst_n   : clock, asynchronous active-low reset
//   byte_valid   : a byte is offered on byte_data
//   byte_data    : byte to send
//   byte_ready   : high only in SER_IDLE; a byte is accepted on valid&&ready
//   tx           : registered serial line, idles high
//
// The idle state doubles as the final clock of the stop bit: SER_STOP holds
// the line high for CLKS_PER_BIT-1 clocks and SER_IDLE supplies the last one.
// A byte offered during that clock starts its start bit on the very next
// clock, so back-to-back frames have no extra idle time and each frame is
// exactly 10*CLKS_PER_BIT clocks. This is why CLKS_PER_BIT must be >= 2.
// -----------------------------------------------------------------------------
module uart_tx_byte
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT - 2);

    ser_state_type    state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [3:0]       bit_idx_r, bit_idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             tx_r, tx_s;

    // Serialiser state, baud counter, bit index, shift register and line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= SER_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 4'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            tx_r      <= tx_s;
        end
    end

    // Next-state logic; the line value for the next clock is computed here
    // so that tx leaves a flop.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        tx_s      = tx_r;
        case (state_r)
            SER_IDLE: begin
                tx_s = 1'b1;
                if (byte_valid) begin
                    shift_s = byte_data;
                    cnt_s   = '0;
                    tx_s    = 1'b0;
                    state_s = SER_START;
                end else begin
                    cnt_s = '0;
                end
            end
            SER_START: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s     = '0;
                    bit_idx_s = 4'd0;
                    tx_s      = shift_r[0];
                    state_s   = SER_DATA;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            SER_DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = '0;
                    if (bit_idx_r == 4'd7) begin
                        tx_s    = 1'b1;
                        state_s = SER_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 4'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            SER_STOP: begin
                tx_s = 1'b1;
                if (cnt_r == STOP_LAST) begin
                    cnt_s   = '0;
                    state_s = SER_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                cnt_s   = '0;
                tx_s    = 1'b1;
                state_s = SER_IDLE;
            end
        endcase
    end

    assign byte_ready = (state_r == SER_IDLE);
    assign tx         = tx_r;

endmodule

// File: rtl/uart_sram_tx_interface.sv
// -----------------------------------------------------------------------------
// uart_sram_tx_interface
// Dumps Word_count 16-bit SRAM words starting at Start_address onto the UART
// line, each word as two 8N1 frames (high byte first).
//   Clock, Resetn   : 50 MHz clock, asynchronous active-low reset
//   Start           : one-cycle request, honoured only in S_TX_IDLE
//   Start_address   : first word address (latched on accepted Start)
//   Word_count      : words to send (latched on accepted Start)
//   Busy            : transfer in progress
//   Done            : one-cycle pulse when the last stop bit has completed
//   SRAM_address    : registered read address (muxed in S_UART_TX_TOP_STATE)
//   SRAM_we_n       : tied high, this block only reads
//   SRAM_read_data  : read data, valid READ_LATENCY edges after an address
//   UART_TX_O       : serial line, idles high
// -----------------------------------------------------------------------------
module uart_sram_tx_interface
    import uart_sram_tx_interface_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int READ_LATENCY = 3
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [SRAM_ADDR_W-1:0] Start_address,
    input  logic [SRAM_ADDR_W-1:0] Word_count,
    output logic                   Busy,
    output logic                   Done,
    output logic [SRAM_ADDR_W-1:0] SRAM_address,
    output logic                   SRAM_we_n,
    input  logic [SRAM_DATA_W-1:0] SRAM_read_data,
    output logic                   UART_TX_O
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_DONE = LAT_W'(READ_LATENCY - 1);

    tx_state_type           state_r, state_s;
    logic [SRAM_ADDR_W-1:0] addr_r, addr_s;
    logic [SRAM_ADDR_W-1:0] remain_r, remain_s;
    logic [SRAM_DATA_W-1:0] word_r, word_s;
    logic [LAT_W-1:0]       lat_r, lat_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   byte_valid_s;
    logic [7:0]             byte_data_s;
    logic                   byte_ready_s;
    logic                   tx_s;

    // Sequencer state and all registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r  <= S_TX_IDLE;
            addr_r   <= 18'd0;
            remain_r <= 18'd0;
            word_r   <= 16'd0;
            lat_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            addr_r   <= addr_s;
            remain_r <= remain_s;
            word_r   <= word_s;
            lat_r    <= lat_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // Word sequencer. lat_r counts edges since the last address load and
    // saturates, so a read issued at the start of the low-byte frame is
    // already satisfied by the time S_TX_WAIT is reached for the next word.
    always_comb begin
        state_s      = state_r;
        addr_s       = addr_r;
        remain_s     = remain_r;
        word_s       = word_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        byte_valid_s = 1'b0;
        byte_data_s  = word_r[15:8];
        if (lat_r == LAT_DONE) begin
            lat_s = lat_r;
        end else begin
            lat_s = lat_r + LAT_ONE;
        end
        case (state_r)
            S_TX_IDLE: begin
                if (Start) begin
                    if (Word_count != 18'd0) begin
                        addr_s   = Start_address;
                        remain_s = Word_count;
                        lat_s    = '0;
                        busy_s   = 1'b1;
                        state_s  = S_TX_WAIT;
                    end else begin
                        // Empty request: acknowledge without touching SRAM.
                        done_s = 1'b1;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            S_TX_WAIT: begin
                if (lat_r == LAT_DONE) begin
                    state_s = S_TX_LATCH;
                end else begin
                    state_s = S_TX_WAIT;
                end
            end
            S_TX_LATCH: begin
                // The high byte goes straight from the read bus so it can be
                // accepted in this same cycle; the serialiser is idle here.
                word_s       = SRAM_read_data;
                byte_valid_s = 1'b1;
                byte_data_s  = SRAM_read_data[15:8];
                if (byte_ready_s) begin
                    state_s = S_TX_SEND_HI;
                end else begin
                    state_s = S_TX_LATCH;
                end
            end
            S_TX_SEND_HI: begin
                byte_valid_s = 1'b1;
                byte_data_s  = word_r[7:0];
                if (byte_ready_s) begin
                    // Entering S_TX_SEND_LO: count the word and address the
                    // next one so its read latency hides under this frame.
                    remain_s = remain_r - 18'd1;
                    addr_s   = next_sram_address(addr_r);
                    lat_s    = '0;
                    state_s  = S_TX_SEND_LO;
                end else begin
                    state_s = S_TX_SEND_HI;
                end
            end
            S_TX_SEND_LO: begin
                if (byte_ready_s) begin
                    if (remain_r == 18'd0) begin
                        // Ready here marks the final stop-bit clock, so the
                        // Done pulse is launched on this edge.
                        done_s  = 1'b1;
                        state_s = S_TX_DONE;
                    end else begin
                        state_s = S_TX_WAIT;
                    end
                end else begin
                    state_s = S_TX_SEND_LO;
                end
            end
            S_TX_DONE: begin
                if (byte_ready_s) begin
                    busy_s  = 1'b0;
                    state_s = S_TX_IDLE;
                end else begin
                    state_s = S_TX_DONE;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_TX_IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk        (Clock),
        .rst_n      (Resetn),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .byte_ready (byte_ready_s),
        .tx         (tx_s)
    );

    assign Busy         = busy_r;
    assign Done         = done_r;
    assign SRAM_address = addr_r;
    assign SRAM_we_n    = 1'b1;
    assign UART_TX_O    = tx_s;

endmodule
